// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and default timing constants for the rPLL lock sequencer.
//
//   pll_state_e   : sequencer state, 3-bit encoding
//   DEF_*         : default timing for a 12 MHz reference clock
//   sat_inc4/8    : saturating increment helpers for the event counters
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // 16 clkin cycles of PLL RESET
  localparam int unsigned DEF_RST_CYCLES    = 16;
  // 1 ms lock window at 12 MHz
  localparam int unsigned DEF_LOCK_TIMEOUT  = 12000;
  // 100 us of continuous lock at 12 MHz
  localparam int unsigned DEF_STABLE_CYCLES = 1200;
  localparam int unsigned DEF_MAX_RETRIES   = 7;
  localparam int unsigned DEF_CNT_W         = 16;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : pll_seq_pkg

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for level signals crossing into clk_i.
//   Both stages clear to 0 on a synchronous active-low reset.
//
//   clk_i   : destination clock
//   rst_ni  : synchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk_i cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Sequences the Gowin rPLL for the pixel clock: pulses PLL RESET, waits for
//   LOCK, qualifies it as stable, then releases the downstream reset. Lock
//   loss re-asserts the downstream reset and re-sequences; repeated failed
//   attempts end in FAULT until restart or rst_n.
//
//   clkin     : free-running PLL reference clock
//   rst_n     : synchronous active-low reset
//   pll_lock  : rPLL LOCK, asynchronous to clkin
//   restart   : single-cycle re-sequence request; also clears FAULT
//   pll_reset : rPLL RESET, active-high
//   rst_out_n : downstream reset, active-low, high only in RUN
//   locked    : high only in RUN
//   fault     : high only in FAULT
//   retry_cnt : failed attempts since last RUN entry / reset, saturating
//   loss_cnt  : lock losses seen in RUN, saturating, cleared only by rst_n
// ---------------------------------------------------------------------------
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q,  loss_d;
  logic             pll_reset_q;
  logic             run_q;
  logic             fault_q;

  logic             lock_s;
  logic [3:0]       retry_inc;
  pll_state_e       fail_state;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (rst_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  // A failed attempt (lock timeout or lock drop while qualifying) bumps the
  // retry count and either retries or gives up, depending on the new count.
  assign retry_inc  = sat_inc4(retry_q);
  assign fail_state = (retry_inc >= RETRY_LIMIT) ? FAULT : RESET_PLL;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      // restart outranks every other transition; only FAULT exit clears retries
      state_d = RESET_PLL;
      timer_d = '0;
      if (state_q == FAULT) begin
        retry_d = '0;
      end
    end else begin
      timer_d = timer_q + CNT_W'(1);
      unique case (state_q)
        RESET_PLL: begin
          if (timer_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end
        end
        WAIT_LOCK: begin
          // lock wins over a coincident timeout
          if (lock_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            retry_d = retry_inc;
            state_d = fail_state;
            timer_d = '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            retry_d = retry_inc;
            state_d = fail_state;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            retry_d = '0;
            state_d = RUN;
            timer_d = '0;
          end
        end
        RUN: begin
          timer_d = '0;
          if (!lock_s) begin
            loss_d  = sat_inc8(loss_q);
            state_d = RESET_PLL;
          end
        end
        FAULT: begin
          timer_d = '0;
        end
        default: begin
          state_d = RESET_PLL;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  // without a combinational decode on the output pins.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      run_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAULT);
      run_q       <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_reset = pll_reset_q;
  assign rst_out_n = run_q;
  assign locked    = run_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule : pll_lock_sequencer

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with shortened timing parameters.
//   Expected values are hand-derived: pll_lock reaches the FSM two edges after
//   it is driven, and outputs follow the state one edge later.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int unsigned P_RST    = 16;
  localparam int unsigned P_LOCK   = 200;
  localparam int unsigned P_STABLE = 40;
  localparam int unsigned P_RETRY  = 7;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       rst_out_n;
  logic       locked;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clkin = ~clkin;

  pll_lock_sequencer #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_LOCK),
    .STABLE_CYCLES (P_STABLE),
    .MAX_RETRIES   (P_RETRY),
    .CNT_W         (16)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .rst_out_n (rst_out_n),
    .locked    (locked),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  // {pll_reset, rst_out_n, locked, fault, retry_cnt, loss_cnt}
  typedef struct {
    string       name;
    logic        rst_n;
    logic        lock;
    logic        restart;
    int unsigned cycles;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] ex(input logic pr, input logic ron,
                                     input logic lk, input logic ft,
                                     input logic [3:0] rt, input logic [7:0] ls);
    return {pr, ron, lk, ft, rt, ls};
  endfunction

  function automatic void add(input string n, input logic rn, input logic lk,
                              input logic rs, input int unsigned cyc,
                              input logic [15:0] e);
    vec_t v;
    v.name    = n;
    v.rst_n   = rn;
    v.lock    = lk;
    v.restart = rs;
    v.cycles  = cyc;
    v.exp     = e;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = {pll_reset, rst_out_n, locked, fault, retry_cnt, loss_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got pr/ron/lk/ft/retry/loss=%b%b%b%b/%0d/%0d expected %b%b%b%b/%0d/%0d",
               name, got[15], got[14], got[13], got[12], got[11:8], got[7:0],
               exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic wait_locked(input string name, input logic val,
                             input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (locked === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok && locked === val) ok = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout got locked=%b expected %b within %0d cycles",
               name, locked, val, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [7:0] exp_loss;

    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;

    //  name          rst_n lock rs cyc   pr ron lk ft retry loss
    add("reset",        0, 0, 0,   2, ex(1, 0, 0, 0, 4'd0, 8'd0));
    add("rstpul_hi",    1, 0, 0,  15, ex(1, 0, 0, 0, 4'd0, 8'd0));
    add("rstpul_lo",    1, 0, 0,   1, ex(0, 0, 0, 0, 4'd0, 8'd0));
    add("wait100",      1, 0, 0, 100, ex(0, 0, 0, 0, 4'd0, 8'd0));
    add("stable_pre",   1, 1, 0,  42, ex(0, 0, 0, 0, 4'd0, 8'd0));
    add("run_entry",    1, 1, 0,   1, ex(0, 1, 1, 0, 4'd0, 8'd0));
    add("run_hold",     1, 1, 0,  50, ex(0, 1, 1, 0, 4'd0, 8'd0));
    add("loss_a",       1, 0, 0,   1, ex(0, 1, 1, 0, 4'd0, 8'd0));
    add("loss_b",       1, 1, 0,   1, ex(0, 1, 1, 0, 4'd0, 8'd0));
    add("loss_drop",    1, 1, 0,   1, ex(1, 0, 0, 0, 4'd0, 8'd1));
    add("reseq_hi",     1, 1, 0,  15, ex(1, 0, 0, 0, 4'd0, 8'd1));
    add("reseq_lo",     1, 1, 0,   1, ex(0, 0, 0, 0, 4'd0, 8'd1));
    add("reseq_stable", 1, 1, 0,  40, ex(0, 0, 0, 0, 4'd0, 8'd1));
    add("reseq_run",    1, 1, 0,   1, ex(0, 1, 1, 0, 4'd0, 8'd1));
    add("restart_run",  1, 1, 1,   1, ex(1, 0, 0, 0, 4'd0, 8'd1));
    add("rs_hi",        1, 1, 0,  15, ex(1, 0, 0, 0, 4'd0, 8'd1));
    add("rs_lo",        1, 1, 0,   1, ex(0, 0, 0, 0, 4'd0, 8'd1));
    add("stable20",     1, 1, 0,  20, ex(0, 0, 0, 0, 4'd0, 8'd1));
    add("glitch_sync",  1, 0, 0,   2, ex(0, 0, 0, 0, 4'd0, 8'd1));
    add("glitch_fail",  1, 0, 0,   1, ex(1, 0, 0, 0, 4'd1, 8'd1));
    add("glitch_hi",    1, 0, 0,  15, ex(1, 0, 0, 0, 4'd1, 8'd1));
    add("glitch_lo",    1, 0, 0,   1, ex(0, 0, 0, 0, 4'd1, 8'd1));
    add("timeout_pre",  1, 0, 0, 199, ex(0, 0, 0, 0, 4'd1, 8'd1));
    add("timeout_fail", 1, 0, 0,   1, ex(1, 0, 0, 0, 4'd2, 8'd1));

    foreach (vecs[i]) begin
      rst_n    = vecs[i].rst_n;
      pll_lock = vecs[i].lock;
      restart  = vecs[i].restart;
      run(vecs[i].cycles);
      restart  = 1'b0;
      check(vecs[i].name, vecs[i].exp);
    end

    // Remaining timeouts up to the retry limit, pulse width checked each time.
    for (int r = 3; r <= 7; r++) begin
      run(15);
      check("to_pulse_hi", ex(1, 0, 0, 0, 4'(r - 1), 8'd1));
      run(1);
      check("to_pulse_lo", ex(0, 0, 0, 0, 4'(r - 1), 8'd1));
      run(199);
      check("to_wait", ex(0, 0, 0, 0, 4'(r - 1), 8'd1));
      run(1);
      check("to_fail", ex(1, 0, 0, (r == 7), 4'(r), 8'd1));
    end

    run(300);
    check("fault_hold", ex(1, 0, 0, 1, 4'd7, 8'd1));
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    check("fault_restart", ex(1, 0, 0, 0, 4'd0, 8'd1));
    run(15);
    check("restart_pulse_hi", ex(1, 0, 0, 0, 4'd0, 8'd1));
    run(1);
    check("restart_pulse_lo", ex(0, 0, 0, 0, 4'd0, 8'd1));

    // restart on the exact edge STABLE would complete
    pll_lock = 1'b1;
    run(42);
    check("prio_pre", ex(0, 0, 0, 0, 4'd0, 8'd1));
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    check("prio_restart", ex(1, 0, 0, 0, 4'd0, 8'd1));
    run(5);
    check("prio_after", ex(1, 0, 0, 0, 4'd0, 8'd1));

    // rst_n (with a coincident restart) in the middle of WAIT_LOCK
    pll_lock = 1'b0;
    run(10);
    check("rw_pulse_hi", ex(1, 0, 0, 0, 4'd0, 8'd1));
    run(1);
    check("rw_pulse_lo", ex(0, 0, 0, 0, 4'd0, 8'd1));
    run(199);
    check("rw_wait", ex(0, 0, 0, 0, 4'd0, 8'd1));
    run(1);
    check("rw_timeout", ex(1, 0, 0, 0, 4'd1, 8'd1));
    run(16);
    run(50);
    check("rw_mid_wait", ex(0, 0, 0, 0, 4'd1, 8'd1));
    rst_n   = 1'b0;
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    check("rw_reset", ex(1, 0, 0, 0, 4'd0, 8'd0));

    // loss_cnt saturation
    rst_n    = 1'b1;
    pll_lock = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      wait_locked("sat_lock", 1'b1, 200, ok);
      if (!ok) break;
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      wait_locked("sat_loss", 1'b0, 6, ok);
      if (!ok) break;
      exp_loss = (i < 255) ? 8'(i) : 8'd255;
      if (i == 1 || i == 128 || i == 254 || i == 255 || i == 256 || i == 300)
        check("sat_loss_cnt", ex(1, 0, 0, 0, 4'd0, exp_loss));
    end
    wait_locked("sat_final_lock", 1'b1, 200, ok);
    check("sat_final", ex(0, 1, 1, 0, 4'd0, 8'd255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pll_lock_sequencer
